mult_shift_sequencer: RTL and testbench

- Parametrised successor to the fixed ×2 sequencer. Computes DST = SRC·2^k (left mode) or DST = SRC/2^k, truncated (right mode), with k supplied at start.
- Drives the register-file decoder selects (A/B read, C write) and the ALU op select, one ALU step per shift.
- Provides a busy/done/error level handshake and detects left-shift overflow through the ALU carry flag.

---
 rtl/mult_shift_sequencer.sv | 133 +++++++++++++
 tb/tb_mult_shift_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_shift_sequencer.sv
// Sequencer that multiplies or divides the source register by 2^k.
// It drives one single-bit ALU shift per step and writes each partial result back to DST.
module mult_shift_sequencer #(
    parameter int SELECTIONALU  = 3,
    parameter int SELECTIONDECO = 3,
    parameter int COUNTW        = 4,
    parameter logic [SELECTIONDECO-1:0] SRC_REG = 3'b110,
    parameter logic [SELECTIONDECO-1:0] DST_REG = 3'b000,
    parameter logic [SELECTIONDECO-1:0] NOWRITE = 3'b111,
    parameter logic [SELECTIONALU-1:0]  ALU_PASS = 3'b000,
    parameter logic [SELECTIONALU-1:0]  ALU_SHL  = 3'b100,
    parameter logic [SELECTIONALU-1:0]  ALU_SHR  = 3'b101
) (
    input  logic                     clk,
    input  logic                     lowRst,
    input  logic                     sStart,
    input  logic                     sMode,
    input  logic [COUNTW-1:0]        sCount,
    input  logic                     sCarry,
    output logic [SELECTIONDECO-1:0] sSelDecoA,
    output logic [SELECTIONDECO-1:0] sSelDecoB,
    output logic [SELECTIONDECO-1:0] sSelDecoC,
    output logic [SELECTIONALU-1:0]  sSelAlu,
    output logic                     sBusy,
    output logic                     sDone,
    output logic                     sErr
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        COPY  = 3'd2,
        SHIFT = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [COUNTW-1:0] count;
    logic              mode;
    logic              first;

    always_ff @(posedge clk or negedge lowRst) begin
        if (!lowRst) begin
            state <= IDLE;
            count <= '0;
            mode  <= 1'b0;
            first <= 1'b1;
        end else begin
            state <= next_state;
            case (state)
                LOAD: begin
                    count <= sCount;
                    mode  <= sMode;
                    first <= 1'b1;
                end
                WRITE: begin
                    first <= 1'b0;
                    // Guarded decrement keeps the counter from wrapping
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        sSelDecoA  = '0;
        sSelDecoB  = '0;
        sSelDecoC  = NOWRITE;
        sSelAlu    = ALU_PASS;
        sBusy      = 1'b0;
        sDone      = 1'b0;
        sErr       = 1'b0;
        case (state)
            IDLE: begin
                if (sStart) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                sBusy      = 1'b1;
                sSelDecoA  = SRC_REG;
                next_state = (sCount == '0) ? COPY : SHIFT;
            end
            COPY: begin
                sBusy      = 1'b1;
                sSelDecoA  = SRC_REG;
                sSelDecoC  = DST_REG;
                next_state = DONE;
            end
            SHIFT: begin
                sBusy      = 1'b1;
                sSelDecoA  = first ? SRC_REG : DST_REG;
                sSelAlu    = mode ? ALU_SHR : ALU_SHL;
                next_state = WRITE;
            end
            WRITE: begin
                sBusy     = 1'b1;
                sSelDecoA = first ? SRC_REG : DST_REG;
                sSelAlu   = mode ? ALU_SHR : ALU_SHL;
                sSelDecoC = DST_REG;
                // The overflowing write still lands, so DST keeps the truncated value
                if (!mode && sCarry) begin
                    next_state = ERROR;
                end else if (count <= COUNTW'(1)) begin
                    next_state = DONE;
                end else begin
                    next_state = SHIFT;
                end
            end
            DONE: begin
                sDone = 1'b1;
                if (!sStart) begin
                    next_state = IDLE;
                end
            end
            ERROR: begin
                sErr = 1'b1;
                if (!sStart) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult_shift_sequencer.sv
// Scoreboard bench for mult_shift_sequencer with an 8-bit register file and ALU model.
// The expected results are computed arithmetically from the source value, the shift count and the mode.
module tb_mult_shift_sequencer;

    localparam logic [2:0] SRC_REG  = 3'b110;
    localparam logic [2:0] DST_REG  = 3'b000;
    localparam logic [2:0] NOWRITE  = 3'b111;
    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_SHL  = 3'b100;
    localparam logic [2:0] ALU_SHR  = 3'b101;

    logic       clk = 1'b0;
    logic       lowRst;
    logic       sStart;
    logic       sMode;
    logic [3:0] sCount;
    logic       sCarry;
    logic [2:0] sSelDecoA;
    logic [2:0] sSelDecoB;
    logic [2:0] sSelDecoC;
    logic [2:0] sSelAlu;
    logic       sBusy;
    logic       sDone;
    logic       sErr;

    logic [7:0] regs [0:7];
    logic [7:0] src_val;
    logic [7:0] a_val;
    logic [7:0] alu_res;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] dst;
        bit         err;
        int         done_cyc;
        int         lat;
        int         writes;
    } exp_t;

    exp_t sb[$];

    mult_shift_sequencer dut (
        .clk(clk), .lowRst(lowRst), .sStart(sStart), .sMode(sMode),
        .sCount(sCount), .sCarry(sCarry), .sSelDecoA(sSelDecoA),
        .sSelDecoB(sSelDecoB), .sSelDecoC(sSelDecoC), .sSelAlu(sSelAlu),
        .sBusy(sBusy), .sDone(sDone), .sErr(sErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Source register is held by the bench; every other register comes from the write port
    always_comb begin
        a_val   = (sSelDecoA == SRC_REG) ? src_val : regs[sSelDecoA];
        alu_res = a_val;
        sCarry  = 1'b0;
        case (sSelAlu)
            ALU_SHL: {sCarry, alu_res} = {a_val, 1'b0};
            ALU_SHR: begin
                alu_res = a_val >> 1;
                sCarry  = a_val[0];
            end
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (sSelDecoC != NOWRITE) regs[sSelDecoC] <= alu_res;
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    // Left-shift overflow happens on the shift that pushes the source's top set bit out of bit 7
    function automatic exp_t model(input logic [7:0] src, input int k, input bit mode);
        exp_t e;
        int   ovf;
        e.err = 1'b0;
        if (k == 0) begin
            e.dst = src; e.lat = 2; e.writes = 1;
        end else if (mode) begin
            e.dst = 8'(src >> k); e.lat = 2 * k + 1; e.writes = k;
        end else begin
            ovf = 99;
            for (int b = 0; b < 8; b++) if (src[b]) ovf = 8 - b;
            if (ovf <= k) begin
                e.err = 1'b1; e.dst = 8'(src << ovf); e.lat = 2 * ovf + 1; e.writes = ovf;
            end else begin
                e.dst = 8'(src << k); e.lat = 2 * k + 1; e.writes = k;
            end
        end
        return e;
    endfunction

    // Monitor: on the first cycle of DONE/ERROR, pop the oldest expectation and compare
    int busy_cnt = 0;
    int write_cnt = 0;
    bit prev_fin = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        bit   fin;
        if (!lowRst) begin
            busy_cnt = 0; write_cnt = 0; prev_fin = 1'b0;
        end else begin
            if (sBusy) busy_cnt++;
            if (sSelDecoC == DST_REG) write_cnt++;
            fin = sDone | sErr;
            if (fin && !prev_fin) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_completion", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_output("done_flag", int'(sDone), int'(!e.err));
                    check_output("err_flag", int'(sErr), int'(e.err));
                    check_output("dst_value", int'(regs[DST_REG]), int'(e.dst));
                    check_output("done_cycle", cyc, e.done_cyc);
                    check_output("busy_cycles", busy_cnt, e.lat);
                    check_output("dst_writes", write_cnt, e.writes);
                    check_output("selB_zero", int'(sSelDecoB), 0);
                end
                busy_cnt = 0; write_cnt = 0;
            end
            prev_fin = fin;
        end
    end

    task automatic apply_stimulus(input logic [7:0] src, input int k, input bit mode, input bit perturb);
        exp_t e;
        int   n;
        @(negedge clk);
        src_val = src;
        sCount  = 4'(k);
        sMode   = mode;
        e = model(src, k, mode);
        e.done_cyc = cyc + 1 + e.lat;
        sb.push_back(e);
        sStart = 1'b1;
        @(posedge clk);
        if (perturb) begin
            @(posedge clk);
            #1;
            sCount = 4'd9;
            sMode  = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sDone | sErr) && n < 100);
        if (!(sDone | sErr)) begin
            check_output("completion_timeout", n, e.lat);
            sb.delete();
            sStart = 1'b0;
            return;
        end
        @(negedge clk);
        check_output("result_held", int'(sDone | sErr), 1);
        sStart = 1'b0;
        @(negedge clk);
        check_output("idle_flags", int'({sDone, sErr, sBusy}), 0);
        check_output("idle_nowrite", int'(sSelDecoC), int'(NOWRITE));
    endtask

    initial begin
        lowRst  = 1'b0;
        sStart  = 1'b0;
        sMode   = 1'b0;
        sCount  = 4'd0;
        src_val = 8'h00;
        repeat (2) @(negedge clk);
        check_output("rst_selA", int'(sSelDecoA), 0);
        check_output("rst_selB", int'(sSelDecoB), 0);
        check_output("rst_selC", int'(sSelDecoC), int'(NOWRITE));
        check_output("rst_alu", int'(sSelAlu), int'(ALU_PASS));
        check_output("rst_flags", int'({sBusy, sDone, sErr}), 0);
        lowRst = 1'b1;
        @(negedge clk);

        apply_stimulus(8'h05, 3, 1'b0, 1'b0);
        apply_stimulus(8'h80, 7, 1'b1, 1'b0);
        apply_stimulus(8'h3C, 0, 1'b0, 1'b0);
        apply_stimulus(8'h90, 2, 1'b0, 1'b0);

        // Abort a k=4 run during its third SHIFT
        @(negedge clk);
        src_val = 8'h05; sCount = 4'd4; sMode = 1'b0; sStart = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2;
        check_output("abort_in_shift_alu", int'(sSelAlu), int'(ALU_SHL));
        lowRst = 1'b0;
        #1;
        check_output("abort_selC", int'(sSelDecoC), int'(NOWRITE));
        check_output("abort_selA", int'(sSelDecoA), 0);
        check_output("abort_alu", int'(sSelAlu), int'(ALU_PASS));
        check_output("abort_busy", int'(sBusy), 0);
        sStart = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #3;
        lowRst = 1'b1;
        @(negedge clk);
        check_output("post_reset_idle", int'({sBusy, sDone, sErr}), 0);
        apply_stimulus(8'h05, 1, 1'b0, 1'b0);

        apply_stimulus(8'h05, 3, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            apply_stimulus(8'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        check_output("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
